// File: rtl/btn_pkg.sv
// Shared types and constants for the button event path.
package btn_pkg;

    localparam int MAX_BTN = 8;
    localparam logic [7:0] DROP_SAT = 8'hFF;

    typedef logic [2:0] btn_id_t;

    function automatic logic [3:0] count_ones(input logic [MAX_BTN-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_BTN; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last+1, wrapping at N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(last) + k) % N);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/button_event_queue.sv
// Captures debounced press pulses, arbitrates them round-robin and queues
// button IDs in a small FIFO drained by the control FSM over valid/ready.
module button_event_queue
    import btn_pkg::*;
#(
    parameter int NUM_BTN = 4,
    parameter int DEPTH   = 4,
    parameter int ID_W    = $clog2(NUM_BTN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic               flush,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] pending,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic [ID_W-1:0]    mem_q [DEPTH];
    logic [ID_W-1:0]    mem_d [DEPTH];

    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               push;
    logic               pop;
    logic [NUM_BTN-1:0] gnt_mask;
    logic [NUM_BTN-1:0] merge;
    logic [MAX_BTN-1:0] merge_ext;
    logic [8:0]         drop_sum;

    rr_arbiter #(
        .N    (NUM_BTN),
        .ID_W (ID_W)
    ) u_arbiter (
        .req       (pending_q),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // A full FIFO blocks the grant even when the head is popped this cycle.
    assign push     = gnt_valid && (count_q < CNT_W'(DEPTH)) && !flush;
    assign pop      = (count_q != '0) && evt_ready && !flush;
    assign gnt_mask = push ? (NUM_BTN'(1) << gnt_id) : '0;
    assign merge    = btn_pulse & pending_q & ~gnt_mask;

    always_comb begin
        pending_d    = pending_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        mem_d        = mem_q;
        merge_ext    = '0;
        merge_ext[NUM_BTN-1:0] = merge;
        drop_sum     = {1'b0, drop_count_q} + {5'b00000, count_ones(merge_ext)};

        if (flush) begin
            pending_d    = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            pending_d = (pending_q & ~gnt_mask) | btn_pulse;
            if (merge != '0) begin
                overflow_d = 1'b1;
            end
            drop_count_d = (drop_sum > {1'b0, DROP_SAT}) ? DROP_SAT : drop_sum[7:0];
            if (push) begin
                mem_d[wr_ptr_q] = gnt_id;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                last_grant_d    = gnt_id;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Last grant resets to the top index so button 0 wins the first search.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            last_grant_q <= ID_W'(NUM_BTN - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            mem_q        <= mem_d;
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_id     = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_button_event_queue;

    localparam int NUM_BTN = 4;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_BTN-1:0] btn_pulse = '0;
    logic               flush = 1'b0;
    logic               evt_ready = 1'b0;
    logic               evt_valid;
    logic [ID_W-1:0]    evt_id;
    logic [NUM_BTN-1:0] pending;
    logic               overflow;
    logic [7:0]         drop_count;

    int compared   = 0;
    int mismatched = 0;

    logic [NUM_BTN-1:0] m_pend;
    int                 m_q[$];
    int                 m_last;
    logic               m_ovf;
    int                 m_drops;

    button_event_queue #(
        .NUM_BTN (NUM_BTN),
        .DEPTH   (DEPTH),
        .ID_W    (ID_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_pulse  (btn_pulse),
        .flush      (flush),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".evt_valid"}, 32'(evt_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".evt_id"}, 32'(evt_id), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        checkOutput({tag, ".pending"}, 32'(pending), 32'(m_pend));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        checkOutput({tag, ".drop_count"}, 32'(drop_count), 32'(m_drops));
    endtask

    task automatic modelReset();
        m_pend  = '0;
        m_q.delete();
        m_last  = NUM_BTN - 1;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs being presented.
    task automatic modelStep();
        int granted;
        int merges;
        int idx;
        if (flush) begin
            m_q.delete();
            m_pend  = '0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            granted = -1;
            merges  = 0;
            if (m_pend != '0 && m_q.size() < DEPTH) begin
                for (int k = 1; k <= NUM_BTN; k++) begin
                    idx = (m_last + k) % NUM_BTN;
                    if (granted < 0 && m_pend[idx]) granted = idx;
                end
            end
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_pulse[i] && m_pend[i] && i != granted) merges++;
            end
            if (granted >= 0) m_pend[granted] = 1'b0;
            m_pend = m_pend | btn_pulse;
            if (merges > 0) m_ovf = 1'b1;
            m_drops = (m_drops + merges > 255) ? 255 : m_drops + merges;
            if (evt_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (granted >= 0) begin
                m_q.push_back(granted);
                m_last = granted;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NUM_BTN-1:0] p, input logic r, input logic f, input string tag);
        btn_pulse = p;
        evt_ready = r;
        flush     = f;
        @(posedge clock);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        #1;
        modelReset();
        checkAll({tag, ".async"});
        btn_pulse = '0;
        flush     = 1'b0;
        evt_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkAll({tag, ".held"});
    endtask

    initial begin
        logic [NUM_BTN-1:0] rp;
        logic               rr;
        logic               rf;
        int                 ready_bias;

        applyReset("reset");

        // single press
        applyStimulus(4'b0100, 1'b1, 1'b0, "t1.pulse");
        applyStimulus(4'b0000, 1'b1, 1'b0, "t1.grant");
        checkOutput("t1.id2", 32'(evt_id), 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b0, "t1.popped");
        applyStimulus(4'b0000, 1'b1, 1'b0, "t1.idle");

        // simultaneous presses straight after reset
        applyReset("t2.reset");
        applyStimulus(4'b1011, 1'b1, 1'b0, "t2.pulse");
        for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 1'b1, 1'b0, "t2.drain");
        checkOutput("t2.drops", 32'(drop_count), 32'd0);

        // round-robin fairness
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0011 : 4'b0000, 1'b1, 1'b0, "t3.rr");
        end
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, 1'b0, "t3.drain");

        // full FIFO and merge
        applyReset("t4.reset");
        applyStimulus(4'b0001, 1'b0, 1'b0, "t4.b0");
        applyStimulus(4'b0010, 1'b0, 1'b0, "t4.b1");
        applyStimulus(4'b0100, 1'b0, 1'b0, "t4.b2");
        applyStimulus(4'b1000, 1'b0, 1'b0, "t4.b3");
        applyStimulus(4'b0000, 1'b0, 1'b0, "t4.full");
        applyStimulus(4'b0010, 1'b0, 1'b0, "t4.b1a");
        applyStimulus(4'b0010, 1'b0, 1'b0, "t4.b1b");
        checkOutput("t4.pending", 32'(pending), 32'b0010);
        checkOutput("t4.overflow", 32'(overflow), 32'd1);
        checkOutput("t4.drops", 32'(drop_count), 32'd1);
        for (int i = 0; i < 7; i++) applyStimulus(4'b0000, 1'b1, 1'b0, "t4.drain");

        // drop counter saturation
        applyReset("t5.reset");
        applyStimulus(4'b0001, 1'b0, 1'b0, "t5.f0");
        applyStimulus(4'b0010, 1'b0, 1'b0, "t5.f1");
        applyStimulus(4'b0100, 1'b0, 1'b0, "t5.f2");
        applyStimulus(4'b1000, 1'b0, 1'b0, "t5.f3");
        applyStimulus(4'b0000, 1'b0, 1'b0, "t5.full");
        for (int i = 0; i < 300; i++) applyStimulus(4'b0001, 1'b0, 1'b0, "t5.sat");
        checkOutput("t5.drops", 32'(drop_count), 32'd255);
        checkOutput("t5.overflow", 32'(overflow), 32'd1);

        // flush with simultaneous pulse, then reset during a pop
        applyReset("t6.reset");
        applyStimulus(4'b0001, 1'b0, 1'b0, "t6.q0");
        applyStimulus(4'b0010, 1'b0, 1'b0, "t6.q1");
        applyStimulus(4'b0100, 1'b0, 1'b0, "t6.q2");
        applyStimulus(4'b0000, 1'b0, 1'b0, "t6.q3");
        applyStimulus(4'b0001, 1'b0, 1'b1, "t6.flush");
        checkOutput("t6.valid", 32'(evt_valid), 32'd0);
        checkOutput("t6.pending", 32'(pending), 32'd0);
        checkOutput("t6.drops", 32'(drop_count), 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, "t6.r0");
        applyStimulus(4'b0010, 1'b0, 1'b0, "t6.r1");
        applyStimulus(4'b0000, 1'b1, 1'b0, "t6.pop");
        applyReset("t6.midpop");

        // random traffic with occasional flush, reset and stalled consumer
        ready_bias = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ready_bias = $urandom_range(0, 4);
            rp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rr = ($urandom_range(0, 3) < ready_bias);
            rf = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 699) == 0) applyReset("rnd.reset");
            applyStimulus(rp, rr, rf, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Collects one-cycle press pulses from the per-button debouncers, arbitrates round-robin among simultaneous presses, and queues them as button-ID events in a small FIFO. The game/menu control FSM drains the FIFO through a valid/ready handshake, so a busy consumer never loses a press. Sits between the debouncer bank and the top-level control FSM.

## Interface
- `NUM_BTN`, default 4: number of debounced buttons. Legal range is 2..8.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, from 2 to 16.
- `ID_W`, default $clog2(NUM_BTN): width of the event ID.
- `clock` — in — 1 — system clock.
- `reset` — in — 1 — asynchronous, active-high.
- `btn_pulse` — in — NUM_BTN — one-cycle press pulses from the debouncers. Bit i is button i.
- `flush` — in — 1 — synchronous clear of the FIFO, pending bits and overflow flag.
- `evt_valid` — out — 1 — the FIFO head is valid.
- `evt_id` — out — ID_W — button index of the FIFO head.
- `evt_ready` — in — 1 — consumer accepts the head. A pop occurs when `evt_valid && evt_ready`.
- `pending` — out — NUM_BTN — presses captured but not yet enqueued.
- `overflow` — out — 1 — sticky; set on any merged press.
- `drop_count` — out — 8 — saturating count of merged presses.

## Operation
**Pending capture**
- `pending[i]` sets at the clock edge when `btn_pulse[i]` is 1.
- `pending[i]` clears at the edge where button i is granted.

**Arbitration**
- One grant per cycle at most.
- A grant requires pending non-empty and FIFO count < DEPTH.
- There is no credit for a simultaneous pop. When the FIFO is full, nothing is granted, even if a pop occurs that cycle.
- Priority is round-robin. The search starts at `last_grant+1` modulo NUM_BTN.
- `last_grant` updates only when a grant occurs. Its reset value is NUM_BTN-1, so button 0 has first priority.
- The granted index is written to the FIFO tail on the same edge.

**Merge cases**
- Pulse on button i while `pending[i]`=1 and i is not granted that cycle: the press merges. `pending[i]` stays 1, `overflow` is set, and `drop_count` increments, saturating at 255.
- Pulse on button i in the same cycle i is granted: `pending[i]` stays 1 as a new press. This is not a merge.

**FIFO**
- Circular buffer with `wr_ptr`, `rd_ptr` and `count` of width $clog2(DEPTH)+1.
- Pointers wrap modulo DEPTH.
- A push and pop in the same cycle leaves `count` unchanged.

**Flush**
- Clears `count`, both pointers, `pending`, `overflow` and `drop_count`.
- `last_grant` is kept.
- `flush` overrides any pulse, grant or pop in that cycle.

**Reset values**
- `evt_valid`=0, `evt_id`=0, `pending`=0, `overflow`=0, `drop_count`=0.
- FIFO is empty.

## Timing
- Pulse at edge t: `pending` is high after edge t. The grant (if free) happens at edge t+1. `evt_valid`=1 after edge t+1. Latency is 2 edges with an empty FIFO; there is no bypass path.
- `evt_id` and `evt_valid` are registered outputs, taken from the FIFO storage head.
- `evt_id` is stable while `evt_valid` is high and `evt_ready` is low.
- Back-to-back pops are sustained at 1 event per cycle.
- Reset asserted mid-operation clears everything immediately, asynchronously. Pulses that occur during reset are lost.

## Structure
- Shared package `btn_pkg`:
  - `MAX_BTN`=8.
  - `btn_id_t` typedef, logic [2:0].
  - `DROP_SAT`=8'hFF.
- Sub-module `rr_arbiter`, parameterized by N.
  - Inputs: `req[N-1:0]`, `last[ID_W-1:0]`.
  - Outputs: `gnt_valid`, `gnt_id`.
  - Purely combinational. The top holds `last_grant`.
- Top module holds the pending register, FIFO storage, counters and flags.

## Test plan
1. **Single press.** Pulse `btn_pulse`=4'b0100 for 1 cycle with `evt_ready`=1. Expect `evt_valid` high exactly 1 cycle, 2 edges later, with `evt_id`=2.
2. **Simultaneous presses.** Pulse 4'b1011 for 1 cycle, directly after reset, with `evt_ready`=1. Expect events in order 0, 1, 3 on consecutive cycles. `drop_count` stays 0.
3. **Round-robin fairness.** Hold `evt_ready`=1 and pulse 4'b0011 every 2 cycles for 8 cycles. Expect IDs to alternate 0, 1, 0, 1 with no starvation.
4. **Full FIFO and merge.** Hold `evt_ready`=0 and pulse buttons 0, 1, 2, 3 on separate cycles (DEPTH=4): expect count 4. Then pulse button 1 twice more. Expect `pending`=4'b0010, `overflow`=1, `drop_count`=1. Raise `evt_ready`: expect 0, 1, 2, 3, then 1.
5. **Saturation.** Keep the FIFO full and pulse button 0 on 300 cycles. Expect `drop_count`=255 and `overflow`=1.
6. **Flush and reset.** With 3 events queued, pulse `flush` together with `btn_pulse`=4'b0001. Expect `evt_valid`=0, `pending`=0 and `drop_count`=0 next cycle. Assert `reset` mid-pop: all outputs are 0 immediately.
